// File: rtl/float64_pkg.sv
// -----------------------------------------------------------------------------
// float64_pkg
// Shared constants for the binary64 normalise/round/pack block: exception flag
// bit positions, exponent limits, round-to-nearest-even increment and mask, and
// the one-hot FSM state encoding.
// -----------------------------------------------------------------------------
package float64_pkg;

  // Exception flag bit positions inside the 5-bit flags word
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_DIVBYZERO = 3;
  localparam int FLAG_INVALID   = 4;

  // Largest biased exponent that can still round to a finite value
  localparam int          EXP_MAX_NORM = 32'h0000_07FD;
  // Biased exponent field of infinity
  localparam logic [10:0] EXP_INF      = 11'h7FF;

  // Half-ULP increment and the mask of the ten bits dropped by rounding
  localparam logic [9:0]  ROUND_INC    = 10'h200;
  localparam logic [9:0]  ROUND_MASK   = 10'h3FF;

  // One-hot controller states
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_NORM = 5'b00010,
    ST_RND  = 5'b00100,
    ST_PACK = 5'b01000,
    ST_DONE = 5'b10000
  } state_e;

endpackage

// File: rtl/float64_clz64.sv
// -----------------------------------------------------------------------------
// float64_clz64
// Combinational 64-bit leading-zero counter.
// Ports:
//   val  in  64  value to examine
//   cnt  out 7   number of leading zeros, 64 when val is zero
// -----------------------------------------------------------------------------
module float64_clz64 (
  input  logic [63:0] val,
  output logic [6:0]  cnt
);

  // Scan upward so that the most significant set bit is the last one to win
  always_comb begin
    cnt = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (val[i]) begin
        cnt = 7'(63 - i);
      end else begin
        cnt = cnt;
      end
    end
  end

endmodule

// File: rtl/norm_round_pack_float64.sv
// -----------------------------------------------------------------------------
// norm_round_pack_float64
// Normalises a raw sign / unbiased exponent / 64-bit significand triple, rounds
// it to nearest-even (tininess detected before rounding) and packs it into an
// IEEE-754 binary64 word with per-operation exception flags.
// Ports:
//   ap_clk, ap_rst_n      clock, asynchronous active-low reset
//   ap_start              request; operands latched when accepted
//   ap_done / ap_ready    result valid (DONE state)
//   ap_idle               IDLE with no pending request
//   zSign, zExp, zSig     operand triple (implicit bit at zSig[62])
//   ap_return             packed binary64 result, held until the next one
//   flags                 {invalid,divbyzero,overflow,underflow,inexact}
//   working_key           locking key; bits [4:3] steer rounding
// -----------------------------------------------------------------------------
module norm_round_pack_float64
  import float64_pkg::*;
#(
  parameter int EXP_W = 16,
  parameter int KEY_W = 129
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic                    zSign,
  input  logic signed [EXP_W-1:0] zExp,
  input  logic [63:0]             zSig,
  output logic [63:0]             ap_return,
  output logic [4:0]              flags,
  input  logic [KEY_W-1:0]        working_key
);

  localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(EXP_MAX_NORM);

  state_e                  state_r, state_nxt_s;
  logic                    sign_r, zero_r, ovf_r;
  logic signed [EXP_W-1:0] zexp_r, exp_r;
  logic [63:0]             zsig_r, sig_r;
  logic [4:0]              flg_r;

  logic [63:0]             inc_s;
  logic                    tie_en_s;
  logic                    unused_key_s;

  logic [6:0]              clz_s;
  logic [EXP_W-1:0]        sc_s;
  logic [63:0]             norm_sig_s;
  logic signed [EXP_W-1:0] norm_exp_s;

  logic [63:0]             sum_s, shr_s, lost_mask_s, rsig_s;
  logic [EXP_W-1:0]        neg_exp_s;
  logic                    unf_s, big_s, ovf_s;
  logic signed [EXP_W-1:0] rexp_s;
  logic [9:0]              rb_s;
  logic [4:0]              rflg_s;

  logic [53:0]             m_s;
  logic [10:0]             pexp_s;
  logic [63:0]             packed_s, result_s;

  // Key bit 3 selects the real half-ULP increment, bit 4 low enables tie-to-even
  assign inc_s        = working_key[3] ? {54'h0, ROUND_INC} : 64'h0;
  assign tie_en_s     = ~working_key[4];
  assign unused_key_s = ^{working_key[KEY_W-1:5], working_key[2:0]};

  assign ap_done  = (state_r == ST_DONE);
  assign ap_ready = ap_done;
  assign ap_idle  = (state_r == ST_IDLE) && !ap_start;

  float64_clz64 u_clz (
    .val (zsig_r),
    .cnt (clz_s)
  );

  // Normalisation: bring the leading one to bit 62 (a set bit 63 shifts right with jam)
  always_comb begin
    sc_s = {{(EXP_W-7){1'b0}}, clz_s} - {{(EXP_W-1){1'b0}}, 1'b1};
    if (clz_s == 7'd0) begin
      norm_sig_s = {1'b0, zsig_r[63:1]} | {63'h0, zsig_r[0]};
    end else begin
      norm_sig_s = zsig_r << (clz_s - 7'd1);
    end
    norm_exp_s = zexp_r - $signed(sc_s);
  end

  // Shared by RND (overflow carry test) and PACK (rounded significand)
  assign sum_s       = sig_r + inc_s;
  assign unf_s       = exp_r[EXP_W-1];
  assign neg_exp_s   = -exp_r;
  assign big_s       = |neg_exp_s[EXP_W-1:6];
  assign shr_s       = sig_r >> neg_exp_s[5:0];
  assign lost_mask_s = (64'h1 << neg_exp_s[5:0]) - 64'h1;
  assign ovf_s       = (exp_r > EXP_MAX_S) || ((exp_r == EXP_MAX_S) && sum_s[63]);

  // Rounding stage: denormalise when the exponent is negative and derive flags
  always_comb begin
    rsig_s = sig_r;
    rexp_s = exp_r;
    rflg_s = 5'h00;
    if (unf_s) begin
      rexp_s = '0;
      if (big_s) begin
        rsig_s = {63'h0, |sig_r};
      end else begin
        rsig_s = shr_s | {63'h0, |(sig_r & lost_mask_s)};
      end
    end else begin
      rsig_s = sig_r;
      rexp_s = exp_r;
    end
    rb_s = rsig_s[9:0] & ROUND_MASK;
    if (zero_r) begin
      rflg_s = 5'h00;
    end else if (ovf_s) begin
      rflg_s[FLAG_OVERFLOW] = 1'b1;
      rflg_s[FLAG_INEXACT]  = 1'b1;
    end else begin
      rflg_s[FLAG_INEXACT]   = |rb_s;
      rflg_s[FLAG_UNDERFLOW] = unf_s & (|rb_s);
    end
  end

  // Packing: rounded significand added onto sign/exponent so a carry bumps the exponent
  always_comb begin
    m_s = sum_s[63:10];
    if (((sig_r[9:0] & ROUND_MASK) == ROUND_INC) && tie_en_s) begin
      m_s[0] = 1'b0;
    end else begin
      m_s[0] = sum_s[10];
    end
    pexp_s   = (m_s == 54'h0) ? 11'h000 : exp_r[10:0];
    packed_s = {sign_r, 63'h0} + {1'b0, pexp_s, 52'h0} + {10'h000, m_s};
    if (zero_r) begin
      result_s = {sign_r, 63'h0};
    end else if (ovf_r) begin
      result_s = {sign_r, EXP_INF, 52'h0};
    end else begin
      result_s = packed_s;
    end
  end

  // Next-state logic: fixed pipeline walk, DONE may accept back-to-back
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = ap_start ? ST_NORM : ST_IDLE;
      ST_NORM: state_nxt_s = ST_RND;
      ST_RND:  state_nxt_s = ST_PACK;
      ST_PACK: state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ap_start ? ST_NORM : ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and per-stage datapath registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r   <= ST_IDLE;
      sign_r    <= 1'b0;
      zexp_r    <= '0;
      zsig_r    <= 64'h0;
      sig_r     <= 64'h0;
      exp_r     <= '0;
      zero_r    <= 1'b0;
      ovf_r     <= 1'b0;
      flg_r     <= 5'h00;
      ap_return <= 64'h0;
      flags     <= 5'h00;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (ap_start) begin
            sign_r <= zSign;
            zexp_r <= zExp;
            zsig_r <= zSig;
          end
        end
        ST_NORM: begin
          sig_r  <= norm_sig_s;
          exp_r  <= norm_exp_s;
          zero_r <= (zsig_r == 64'h0);
        end
        ST_RND: begin
          sig_r <= rsig_s;
          exp_r <= rexp_s;
          ovf_r <= ovf_s;
          flg_r <= rflg_s;
        end
        ST_PACK: begin
          ap_return <= result_s;
          flags     <= flg_r;
        end
        default: begin
          sig_r <= sig_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_round_pack_float64.sv
module tb_norm_round_pack_float64;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         ap_start = 1'b0;
  logic         ap_done, ap_idle, ap_ready;
  logic         zSign = 1'b0;
  logic [15:0]  zExp = 16'h0;
  logic [63:0]  zSig = 64'h0;
  logic [63:0]  ap_return;
  logic [4:0]   flags;
  logic [128:0] key;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  norm_round_pack_float64 dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .zSign       (zSign),
    .zExp        (zExp),
    .zSig        (zSig),
    .ap_return   (ap_return),
    .flags       (flags),
    .working_key (key)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [15:0] e,
                        input logic [63:0] g, input logic [63:0] r, input logic [4:0] f);
    int n;
    @(negedge ap_clk);
    zSign = s; zExp = e; zSig = g; ap_start = 1'b1;
    n = 0;
    do begin
      @(posedge ap_clk);
      n++;
      #1 ap_start = 1'b0;
    end while (!ap_done && n < 20);
    check_val({tag, "_lat"}, 64'(n), 64'd4);
    check_val({tag, "_ret"}, ap_return, r);
    check_val({tag, "_flg"}, {59'h0, flags}, {59'h0, f});
  endtask

  initial begin
    key = {129{1'b1}};
    key[4] = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check_val("rst_ret", ap_return, 64'h0);
    check_val("rst_flg", {59'h0, flags}, 64'h0);
    check_val("rst_done", {63'h0, ap_done}, 64'h0);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    #1 check_val("rst_idle", {63'h0, ap_idle}, 64'h1);

    run_op("one",      1'b0, 16'h03FE, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'h00);
    run_op("norm2",    1'b0, 16'h0400, 64'h1000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'h00);
    run_op("shr1",     1'b0, 16'h03FD, 64'h8000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 5'h01);
    run_op("tie",      1'b0, 16'h03FE, 64'h4000_0000_0000_0200, 64'h3FF0_0000_0000_0000, 5'h01);
    key[4] = 1'b1;
    run_op("tie_nclr", 1'b0, 16'h03FE, 64'h4000_0000_0000_0200, 64'h3FF0_0000_0000_0001, 5'h01);
    key[4] = 1'b0;
    run_op("rcarry",   1'b0, 16'h03FE, 64'h7FFF_FFFF_FFFF_FE00, 64'h4000_0000_0000_0000, 5'h01);
    run_op("maxnorm",  1'b0, 16'h07FD, 64'h4000_0000_0000_0000, 64'h7FE0_0000_0000_0000, 5'h00);
    run_op("ovf_car",  1'b0, 16'h07FD, 64'h7FFF_FFFF_FFFF_FE00, 64'h7FF0_0000_0000_0000, 5'h05);
    run_op("ovf",      1'b1, 16'h07FE, 64'h4000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 5'h05);
    run_op("unf",      1'b0, 16'hFFFF, 64'h4000_0000_0000_0001, 64'h0008_0000_0000_0000, 5'h03);
    run_op("unf_big",  1'b0, 16'hFF00, 64'h4000_0000_0000_0000, 64'h0000_0000_0000_0000, 5'h03);
    run_op("zero",     1'b1, 16'h0123, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'h00);

    // Back-to-back with ap_start held; operands changed mid-operation must be ignored
    @(negedge ap_clk);
    zSign = 1'b0; zExp = 16'h03FE; zSig = 64'h4000_0000_0000_0000; ap_start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge ap_clk);
      #1;
      check_val("b2b_done", {63'h0, ap_done}, {63'h0, (n % 4 == 0)});
      if (n == 2) begin
        zSign = 1'b1; zExp = 16'h0000; zSig = 64'h0;
      end
      if (n == 4) begin
        check_val("b2b_r1", ap_return, 64'h3FF0_0000_0000_0000);
        zSign = 1'b0; zExp = 16'h07FD; zSig = 64'h7FFF_FFFF_FFFF_FE00;
      end
      if (n == 8) begin
        check_val("b2b_r2", ap_return, 64'h7FF0_0000_0000_0000);
        check_val("b2b_f2", {59'h0, flags}, 64'h05);
        zSign = 1'b0; zExp = 16'h03FE; zSig = 64'h7FFF_FFFF_FFFF_FE00;
      end
      if (n == 12) begin
        check_val("b2b_r3", ap_return, 64'h4000_0000_0000_0000);
        check_val("b2b_f3", {59'h0, flags}, 64'h01);
        ap_start = 1'b0;
      end
    end

    // Reset asserted while the operation sits in RND
    @(negedge ap_clk);
    zSign = 1'b0; zExp = 16'h03FE; zSig = 64'h4000_0000_0000_0200; ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    #1;
    check_val("mid_ret", ap_return, 64'h0);
    check_val("mid_flg", {59'h0, flags}, 64'h0);
    check_val("mid_done", {63'h0, ap_done}, 64'h0);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge ap_clk);
      #1;
      check_val("post_done", {63'h0, ap_done}, 64'h0);
      check_val("post_idle", {63'h0, ap_idle}, 64'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
